// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// States, LCD message codes, coin values and the credit width.
package vend_pkg;

    localparam int CREDIT_W = 8;

    typedef enum logic [1:0] {
        ST_COIN     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_RETRY    = 2'd3
    } state_t;

    localparam logic [1:0] MSG_VALUE   = 2'd0;
    localparam logic [1:0] MSG_PRODUCT = 2'd1;
    localparam logic [1:0] MSG_CHANGE  = 2'd2;
    localparam logic [1:0] MSG_RETRY   = 2'd3;

    localparam logic [3:0] COIN_1 = 4'd1;
    localparam logic [3:0] COIN_2 = 4'd2;
    localparam logic [3:0] COIN_5 = 4'd5;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]}
                  + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button -> 2-FF synchroniser, stable counter,
// and a one-cycle pulse when a debounced press is accepted.
module btn_debounce #(
    parameter int unsigned CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic press
);

    localparam int CW = $clog2(CYCLES + 1);

    logic          s0;
    logic          s1;
    logic          held;
    logic [CW-1:0] cnt;
    logic          lvl;

    assign lvl = ~s1;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            s0 <= raw_n;
            s1 <= s0;
        end
    end

    // Accept a new level only after it has been stable CYCLES clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held  <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (lvl == held) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                held  <= lvl;
                cnt   <= '0;
                press <= lvl;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: debounced buttons, credit, pricing, FSM.
// Optional idle timeout back to COIN when VEND_TIMEOUT_EN is defined.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000,
    parameter int unsigned PRICE_PER_ITEM  = 2,
    parameter int unsigned MAX_CREDIT      = 99
) (
    input  logic       iCLK_50MHZ,
    input  logic       iRST,
    input  logic       b1_n,
    input  logic       b2_n,
    input  logic       b5_n,
    input  logic       bOK_n,
    input  logic [3:0] chave,
    output logic [7:0] credit,
    output logic [7:0] total_due,
    output logic [7:0] change,
    output logic       change_valid,
    output logic       dispense,
    output logic [1:0] msg_sel
);

    state_t     state;
    state_t     next;
    logic       p1, p2, p5, pok;
    logic       timeout;
    logic [3:0] coin_sum;
    logic [8:0] sum9;
    logic [7:0] credit_n;
    logic [7:0] change_n;
    logic [7:0] due_n;
    logic       cv_n;
    logic       disp_n;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_b1 (
        .clk(iCLK_50MHZ), .rst(iRST), .raw_n(b1_n), .press(p1));
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_b2 (
        .clk(iCLK_50MHZ), .rst(iRST), .raw_n(b2_n), .press(p2));
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_b5 (
        .clk(iCLK_50MHZ), .rst(iRST), .raw_n(b5_n), .press(p5));
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ok (
        .clk(iCLK_50MHZ), .rst(iRST), .raw_n(bOK_n), .press(pok));

`ifdef VEND_TIMEOUT_EN
    logic [31:0] idle;
    logic        any_p;

    assign any_p   = p1 | p2 | p5 | pok;
    assign timeout = (idle == 32'(TIMEOUT_CYCLES));

    // Idle counter: held in COIN, cleared by any press, counts elsewhere.
    always_ff @(posedge iCLK_50MHZ or posedge iRST) begin
        if (iRST) begin
            idle <= '0;
        end else if (state == ST_COIN || any_p) begin
            idle <= '0;
        end else if (!timeout) begin
            idle <= idle + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge iCLK_50MHZ or posedge iRST) begin
        if (iRST) begin
            state        <= ST_COIN;
            credit       <= '0;
            change       <= '0;
            total_due    <= '0;
            change_valid <= 1'b0;
            dispense     <= 1'b0;
        end else begin
            state        <= next;
            credit       <= credit_n;
            change       <= change_n;
            total_due    <= due_n;
            change_valid <= cv_n;
            dispense     <= disp_n;
        end
    end

    // Next state, saturating credit, pricing and change computation.
    always_comb begin
        next     = state;
        credit_n = credit;
        change_n = change;
        due_n    = total_due;
        cv_n     = change_valid;
        disp_n   = 1'b0;
        coin_sum = (p1 ? COIN_1 : 4'd0) + (p2 ? COIN_2 : 4'd0)
                 + (p5 ? COIN_5 : 4'd0);
        sum9     = {1'b0, credit} + {5'b0, coin_sum};
        unique case (state)
            ST_COIN: begin
                if (sum9 > 9'(MAX_CREDIT)) credit_n = 8'(MAX_CREDIT);
                else                       credit_n = sum9[7:0];
                if (pok) next = ST_SELECT;
            end
            ST_SELECT: begin
                due_n = 8'(PRICE_PER_ITEM * int'(popcount4(chave)));
                if (pok) begin
                    if (credit >= total_due) begin
                        next     = ST_DISPENSE;
                        change_n = credit - total_due;
                        credit_n = '0;
                        cv_n     = 1'b1;
                        disp_n   = (total_due != 8'd0);
                    end else begin
                        next = ST_RETRY;
                    end
                end else if (timeout) begin
                    next = ST_COIN;
                end
            end
            ST_DISPENSE: begin
                if (pok || timeout) begin
                    next     = ST_COIN;
                    change_n = '0;
                    cv_n     = 1'b0;
                end
            end
            ST_RETRY: begin
                if (pok || timeout) next = ST_COIN;
            end
        endcase
    end

    // LCD message follows the state.
    always_comb begin
        msg_sel = MSG_VALUE;
        unique case (state)
            ST_COIN:     msg_sel = MSG_VALUE;
            ST_SELECT:   msg_sel = MSG_PRODUCT;
            ST_DISPENSE: msg_sel = MSG_CHANGE;
            ST_RETRY:    msg_sel = MSG_RETRY;
        endcase
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: transaction-level model, per-cycle compare,
// directed scenarios plus randomized button/switch activity.
module tb_vend_txn_ctrl;

    localparam int DEB   = 4;
    localparam int TOUT  = 50;
    localparam int PRICE = 2;
    localparam int MAXC  = 99;
    localparam int HOLD  = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b1_n = 1'b1, b2_n = 1'b1, b5_n = 1'b1, bOK_n = 1'b1;
    logic [3:0] chave = 4'd0;
    logic [7:0] credit, total_due, change;
    logic       change_valid, dispense;
    logic [1:0] msg_sel;

    int passed = 0;
    int total  = 0;
    int disp_seen = 0;
    bit settled = 0;

    int m_state = 0;
    int m_credit = 0;
    int m_due = 0;
    int m_change = 0;
    int m_disp = 0;

    vend_txn_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TOUT),
        .PRICE_PER_ITEM(PRICE), .MAX_CREDIT(MAXC)
    ) dut (
        .iCLK_50MHZ(clk), .iRST(rst),
        .b1_n(b1_n), .b2_n(b2_n), .b5_n(b5_n), .bOK_n(bOK_n),
        .chave(chave), .credit(credit), .total_due(total_due),
        .change(change), .change_valid(change_valid),
        .dispense(dispense), .msg_sel(msg_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int pop(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i]) n++;
        return n;
    endfunction

    // Per-cycle comparison whenever no button activity is in flight.
    always @(posedge clk) begin
        #1;
        if (dispense) disp_seen++;
        if (settled && !rst) begin
            check("msg_sel", int'(msg_sel), m_state);
            check("credit", int'(credit), m_credit);
            check("total_due", int'(total_due), m_due);
            check("change", int'(change), m_change);
            check("change_valid", int'(change_valid),
                  (m_state == 2) ? 1 : 0);
            check("dispense_idle", int'(dispense), 0);
        end
    end

    // Model of one accepted press; m = {ok, b5, b2, b1}.
    task automatic model_apply(input logic [3:0] m);
        int sum;
        sum = (m[0] ? 1 : 0) + (m[1] ? 2 : 0) + (m[2] ? 5 : 0);
        m_disp = 0;
        case (m_state)
            0: begin
                m_credit = (m_credit + sum > MAXC) ? MAXC : m_credit + sum;
                if (m[3]) m_state = 1;
            end
            1: if (m[3]) begin
                if (m_credit >= m_due) begin
                    m_state  = 2;
                    m_change = m_credit - m_due;
                    m_credit = 0;
                    m_disp   = (m_due != 0) ? 1 : 0;
                end else begin
                    m_state = 3;
                end
            end
            2: if (m[3]) begin
                m_state  = 0;
                m_change = 0;
            end
            default: if (m[3]) m_state = 0;
        endcase
        if (m_state == 1) m_due = PRICE * pop(chave);
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk);
        settled   = 0;
        disp_seen = 0;
        b1_n  = ~m[0];
        b2_n  = ~m[1];
        b5_n  = ~m[2];
        bOK_n = ~m[3];
        repeat (HOLD) @(negedge clk);
        b1_n = 1; b2_n = 1; b5_n = 1; bOK_n = 1;
        repeat (HOLD) @(negedge clk);
        model_apply(m);
        check("dispense_pulses", disp_seen, m_disp);
        settled = 1;
    endtask

    task automatic set_chave(input logic [3:0] v);
        @(negedge clk);
        settled = 0;
        chave = v;
        repeat (3) @(negedge clk);
        if (m_state == 1) m_due = PRICE * pop(chave);
        settled = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m;
        int last_chave;
        repeat (3) @(negedge clk);
        rst = 0;
        settled = 1;
        @(negedge clk);
        check("reset_msg", int'(msg_sel), 0);
        check("reset_credit", int'(credit), 0);
        check("reset_dispense", int'(dispense), 0);

        press(4'b0010); check("t1_credit2", int'(credit), 2);
        press(4'b0100); check("t1_credit7", int'(credit), 7);
        press(4'b0001); check("t1_credit8", int'(credit), 8);
        press(4'b1000); check("t1_msg", int'(msg_sel), 1);

        set_chave(4'b0111);
        check("t2_due", int'(total_due), 6);
        press(4'b1000);
        check("t2_msg", int'(msg_sel), 2);
        check("t2_change", int'(change), 2);
        check("t2_credit", int'(credit), 0);
        check("t2_disp", disp_seen, 1);
        press(4'b1000);
        check("t2_back", int'(msg_sel), 0);
        check("t2_change0", int'(change), 0);

        press(4'b0001);
        press(4'b0010);
        press(4'b1000);
        set_chave(4'b1111);
        press(4'b1000);
        check("t3_msg", int'(msg_sel), 3);
        check("t3_credit", int'(credit), 3);
        press(4'b1000);
        check("t3_coin", int'(msg_sel), 0);
        press(4'b0100);
        check("t3_credit8", int'(credit), 8);

        for (int i = 0; i < 20; i++) press(4'b0100);
        check("t4_sat", int'(credit), 99);
        press(4'b1000);
        set_chave(4'b0000);
        press(4'b1000);
        check("t4_refund", int'(change), 99);
        check("t4_nodisp", disp_seen, 0);
        press(4'b1000);
        press(4'b0011);
        check("t4_pair", int'(credit), 3);

        @(negedge clk);
        settled = 0;
        for (int i = 0; i < 10; i++) begin
            b1_n = (i % 2 == 1);
            repeat (2) @(negedge clk);
        end
        b1_n = 0;
        repeat (HOLD) @(negedge clk);
        b1_n = 1;
        repeat (HOLD) @(negedge clk);
        model_apply(4'b0001);
        settled = 1;
        check("t5_bounce", int'(credit), 4);

        press(4'b1000);
        press(4'b1000);
        check("t5_in_disp", int'(msg_sel), 2);
        @(negedge clk);
        settled = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        check("t5_rst_msg", int'(msg_sel), 0);
        check("t5_rst_change", int'(change), 0);
        check("t5_rst_cv", int'(change_valid), 0);
        check("t5_rst_due", int'(total_due), 0);
        rst = 0;
        m_state = 0; m_credit = 0; m_due = 0; m_change = 0;
        @(negedge clk);
        settled = 1;

        press(4'b0001);
        press(4'b1000);
`ifdef VEND_TIMEOUT_EN
        settled = 0;
        repeat (TOUT + 20) @(negedge clk);
        m_state = 0;
        settled = 1;
        @(negedge clk);
        check("t6_timeout", int'(msg_sel), 0);
        check("t6_credit", int'(credit), 1);
`else
        repeat (200) @(negedge clk);
        check("t6_wait", int'(msg_sel), 1);
`endif

        last_chave = 0;
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r >= 8 && !last_chave) begin
                m = 4'($urandom_range(0, 15));
                set_chave(m);
                last_chave = 1;
            end else begin
                if (r <= 3)      m = {1'b0, 3'($urandom_range(1, 7))};
                else if (r == 7) m = {1'b1, 3'($urandom_range(1, 7))};
                else             m = 4'b1000;
                press(m);
                last_chave = 0;
            end
        end

        settled = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
